vcr_regfile: RTL and testbench

Parametrised Vendor Command/Request (VCR) endpoint. The EZ-USB drives it over an 8-bit address/data bus plus a strobe line.
- Generalises the fixed-address VCR decoder into two windows: a writable control-register window and a readable status window, both with auto-incrementing burst access.
- Status reads return a coherent snapshot taken at address time.
- Adds stall timeout, an error counter and an echo self-test.
- Sits between the USB-side I/O pins and the application control/status logic.

---
 rtl/vcr_regfile.sv | 177 +++++++++++++++++
 tb/tb_vcr_regfile.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcr_regfile.sv
// rtl/vcr_regfile.sv - VCR endpoint: control-register write window, snapshot status window, echo self-test
// Host strobe is synchronised and edge-detected; each strobe moves one byte through the state machine.
module vcr_regfile #(
   parameter int N_CTRL        = 8,
   parameter int N_STAT        = 8,
   parameter int CTRL_BASE     = 'hA0,
   parameter int STAT_BASE     = 'hC0,
   parameter int ECHO_ADDR     = 'h88,
   parameter int STALL_TIMEOUT = 50000
) (
   input  logic                  IFCLK,
   input  logic                  RESET_N,
   input  logic                  CS,
   input  logic [7:0]            vcr_in,
   input  logic                  vcr_clk_in,
   output logic [7:0]            vcr_out,
   output logic                  vcr_oe,
   input  logic [8*N_STAT-1:0]   stat_in,
   output logic [8*N_CTRL-1:0]   ctrl_out,
   output logic [N_CTRL-1:0]     ctrl_wr,
   output logic                  busy,
   output logic [7:0]            err_count
);

   localparam int PW = 6;

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WR, S_RD} state_t;

   state_t                r_state;
   logic [7:0]            r_din;
   logic                  r_clk1, r_clk2, r_clk3;
   logic [7:0]            r_addr;
   logic [PW-1:0]         r_ptr;
   logic                  r_echo_mode;
   logic [8*N_CTRL-1:0]   r_ctrl;
   logic [N_CTRL-1:0]     r_ctrl_wr;
   logic [31:0]           r_echo;
   logic [8*N_STAT-1:0]   r_snap;
   logic [31:0]           r_timer;
   logic [7:0]            r_err;
   logic [7:0]            r_out;

   logic                  w_strobe;
   logic                  w_in_ctrl, w_in_stat, w_is_echo;
   logic                  w_timeout, w_last_rd;
   logic [7:0]            w_snap_byte, w_echo_byte, w_err_next;

   assign w_strobe   = r_clk2 & ~r_clk3 & CS;
   assign w_in_ctrl  = (int'(r_addr) >= CTRL_BASE) && (int'(r_addr) < CTRL_BASE + N_CTRL);
   assign w_in_stat  = (int'(r_addr) >= STAT_BASE) && (int'(r_addr) < STAT_BASE + N_STAT);
   assign w_is_echo  = (int'(r_addr) == ECHO_ADDR);
   assign w_timeout  = (r_timer == 32'(STALL_TIMEOUT - 1));
   assign w_last_rd  = r_echo_mode ? (r_ptr == PW'(3)) : (r_ptr == PW'(N_STAT - 1));
   assign w_err_next = (r_err == 8'hFF) ? 8'hFF : r_err + 8'd1;

   always_comb begin
      w_snap_byte = 8'h00;
      for (int k = 0; k < N_STAT; k++)
         if (r_ptr == PW'(k)) w_snap_byte = r_snap[8*k +: 8];
      w_echo_byte = 8'h00;
      for (int k = 0; k < 4; k++)
         if (r_ptr == PW'(k)) w_echo_byte = r_echo[8*k +: 8];
   end

   always_ff @(posedge IFCLK) begin
      if (!RESET_N) begin
         r_state     <= S_IDLE;
         r_din       <= 8'h00;
         r_clk1      <= 1'b0;
         r_clk2      <= 1'b0;
         r_clk3      <= 1'b0;
         r_addr      <= 8'h00;
         r_ptr       <= '0;
         r_echo_mode <= 1'b0;
         r_ctrl      <= '0;
         r_ctrl_wr   <= '0;
         r_echo      <= '0;
         r_snap      <= '0;
         r_timer     <= '0;
         r_err       <= 8'h00;
         r_out       <= 8'h00;
      end else begin
         r_din     <= vcr_in;
         r_clk1    <= vcr_clk_in;
         r_clk2    <= r_clk1;
         r_clk3    <= r_clk2;
         r_ctrl_wr <= '0;
         r_out     <= (r_state == S_RD) ? (r_echo_mode ? (w_echo_byte ^ 8'h5A) : w_snap_byte) : 8'h00;

         if (!CS) begin
            r_state <= S_IDLE;
            r_timer <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_timer <= '0;
                  if (w_strobe) begin
                     r_addr  <= r_din;
                     r_ptr   <= '0;
                     r_state <= S_DECODE;
                  end
               end
               S_DECODE: begin
                  r_timer <= '0;
                  // Control window is tested first so it wins on overlapping parameterisations.
                  if (w_in_ctrl) begin
                     r_ptr       <= PW'(r_addr - 8'(CTRL_BASE));
                     r_echo_mode <= 1'b0;
                     r_state     <= S_WR;
                  end else if (w_in_stat) begin
                     r_ptr       <= PW'(r_addr - 8'(STAT_BASE));
                     r_snap      <= stat_in;
                     r_echo_mode <= 1'b0;
                     r_state     <= S_RD;
                  end else if (w_is_echo) begin
                     r_ptr       <= '0;
                     r_echo_mode <= 1'b1;
                     r_state     <= S_WR;
                  end else begin
                     r_err   <= w_err_next;
                     r_state <= S_IDLE;
                  end
               end
               S_WR: begin
                  if (w_strobe) begin
                     r_timer <= '0;
                     if (r_echo_mode) begin
                        for (int k = 0; k < 4; k++)
                           if (r_ptr == PW'(k)) r_echo[8*k +: 8] <= r_din;
                        if (r_ptr == PW'(3)) begin
                           r_ptr   <= '0;
                           r_state <= S_RD;
                        end else begin
                           r_ptr <= r_ptr + PW'(1);
                        end
                     end else begin
                        for (int k = 0; k < N_CTRL; k++)
                           if (r_ptr == PW'(k)) begin
                              r_ctrl[8*k +: 8] <= r_din;
                              r_ctrl_wr[k]     <= 1'b1;
                           end
                        if (r_ptr == PW'(N_CTRL - 1)) r_state <= S_IDLE;
                        else                          r_ptr   <= r_ptr + PW'(1);
                     end
                  end else if (w_timeout) begin
                     r_err   <= w_err_next;
                     r_state <= S_IDLE;
                  end else begin
                     r_timer <= r_timer + 32'd1;
                  end
               end
               S_RD: begin
                  if (w_strobe) begin
                     r_timer <= '0;
                     if (w_last_rd) r_state <= S_IDLE;
                     else           r_ptr   <= r_ptr + PW'(1);
                  end else if (w_timeout) begin
                     r_err   <= w_err_next;
                     r_state <= S_IDLE;
                  end else begin
                     r_timer <= r_timer + 32'd1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign vcr_out   = r_out;
   assign vcr_oe    = CS && (r_state == S_RD);
   assign ctrl_out  = r_ctrl;
   assign ctrl_wr   = r_ctrl_wr;
   assign busy      = (r_state != S_IDLE);
   assign err_count = r_err;

endmodule

// File: tb/tb_vcr_regfile.sv
// tb/tb_vcr_regfile.sv - bench for vcr_regfile: decode table, directed corner cases, random transactions vs model
module tb_vcr_regfile;

   localparam int NC = 8;
   localparam int NS = 8;
   localparam int TO = 300;
   localparam int CB = 'hA0;
   localparam int SB = 'hC0;
   localparam int EA = 'h88;

   logic              IFCLK = 1'b0;
   logic              RESET_N = 1'b0;
   logic              CS = 1'b1;
   logic [7:0]        vcr_in = 8'h00;
   logic              vcr_clk_in = 1'b0;
   logic [7:0]        vcr_out;
   logic              vcr_oe;
   logic [8*NS-1:0]   stat_in = '0;
   logic [8*NC-1:0]   ctrl_out;
   logic [NC-1:0]     ctrl_wr;
   logic              busy;
   logic [7:0]        err_count;

   vcr_regfile #(
      .N_CTRL(NC), .N_STAT(NS), .CTRL_BASE(CB), .STAT_BASE(SB),
      .ECHO_ADDR(EA), .STALL_TIMEOUT(TO)
   ) dut (
      .IFCLK(IFCLK), .RESET_N(RESET_N), .CS(CS), .vcr_in(vcr_in), .vcr_clk_in(vcr_clk_in),
      .vcr_out(vcr_out), .vcr_oe(vcr_oe), .stat_in(stat_in), .ctrl_out(ctrl_out),
      .ctrl_wr(ctrl_wr), .busy(busy), .err_count(err_count)
   );

   always #5 IFCLK = ~IFCLK;

   int n_vec = 0;
   int n_fail = 0;

   logic [7:0] ctrl_m [NC];
   logic [7:0] snap_m [NS];
   logic [7:0] echo_m [4];
   logic [7:0] err_m;
   logic [NC-1:0] wr_log [$];

   typedef struct {
      logic [7:0] addr;
      logic       exp_busy;
      int         exp_err_inc;
   } dec_vec_t;
   dec_vec_t tbl [12];

   always @(negedge IFCLK) if (ctrl_wr != '0) wr_log.push_back(ctrl_wr);

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pulse(input logic [7:0] b);
      @(negedge IFCLK);
      vcr_in = b;
      vcr_clk_in = 1'b1;
      repeat (4) @(negedge IFCLK);
      vcr_clk_in = 1'b0;
      repeat (4) @(negedge IFCLK);
   endtask

   task automatic cs_abort();
      @(negedge IFCLK);
      CS = 1'b0;
      repeat (2) @(negedge IFCLK);
      CS = 1'b1;
      @(negedge IFCLK);
   endtask

   task automatic read_byte(input string nm, input logic [7:0] exp);
      check(nm, {56'd0, vcr_out}, {56'd0, exp});
      check({nm, "_oe"}, {63'd0, vcr_oe}, 64'd1);
      pulse(8'h00);
   endtask

   function automatic logic [8*NC-1:0] ctrl_packed();
      logic [8*NC-1:0] v;
      for (int i = 0; i < NC; i++) v[8*i +: 8] = ctrl_m[i];
      return v;
   endfunction

   function automatic bit addr_valid(input int a);
      return (a >= CB && a < CB + NC) || (a >= SB && a < SB + NS) || (a == EA);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s, l, kind, a, cyc;
      logic [7:0] d;
      logic [63:0] sv;

      for (int i = 0; i < NC; i++) ctrl_m[i] = 8'h00;
      err_m = 8'h00;

      tbl[0]  = '{8'h10, 1'b0, 1};
      tbl[1]  = '{8'h9F, 1'b0, 1};
      tbl[2]  = '{8'hA0, 1'b1, 0};
      tbl[3]  = '{8'hA7, 1'b1, 0};
      tbl[4]  = '{8'hA8, 1'b0, 1};
      tbl[5]  = '{8'hBF, 1'b0, 1};
      tbl[6]  = '{8'hC0, 1'b1, 0};
      tbl[7]  = '{8'hC7, 1'b1, 0};
      tbl[8]  = '{8'hC8, 1'b0, 1};
      tbl[9]  = '{8'h88, 1'b1, 0};
      tbl[10] = '{8'h87, 1'b0, 1};
      tbl[11] = '{8'h89, 1'b0, 1};

      repeat (3) @(negedge IFCLK);
      check("rst_ctrl_out", ctrl_out, 64'd0);
      check("rst_ctrl_wr", {56'd0, ctrl_wr}, 64'd0);
      check("rst_err", {56'd0, err_count}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_oe", {63'd0, vcr_oe}, 64'd0);
      check("rst_out", {56'd0, vcr_out}, 64'd0);
      RESET_N = 1'b1;
      repeat (2) @(negedge IFCLK);

      for (int i = 0; i < 12; i++) begin
         pulse(tbl[i].addr);
         check($sformatf("dec_busy_%h", tbl[i].addr), {63'd0, busy}, {63'd0, tbl[i].exp_busy});
         if (tbl[i].exp_err_inc != 0) err_m = sat_inc(err_m);
         check($sformatf("dec_err_%h", tbl[i].addr), {56'd0, err_count}, {56'd0, err_m});
         cs_abort();
      end

      wr_log.delete();
      pulse(8'hA2); pulse(8'h11); pulse(8'h22);
      ctrl_m[2] = 8'h11; ctrl_m[3] = 8'h22;
      check("t1_ctrl", ctrl_out, ctrl_packed());
      check("t1_busy", {63'd0, busy}, 64'd1);
      check("t1_wr_count", 64'(wr_log.size()), 64'd2);
      if (wr_log.size() == 2) begin
         check("t1_wr0", {56'd0, wr_log[0]}, 64'h04);
         check("t1_wr1", {56'd0, wr_log[1]}, 64'h08);
      end
      cs_abort();

      pulse(8'hA6); pulse(8'h01); pulse(8'h02);
      ctrl_m[6] = 8'h01; ctrl_m[7] = 8'h02;
      check("t2_ctrl", ctrl_out, ctrl_packed());
      check("t2_busy", {63'd0, busy}, 64'd0);

      stat_in = 64'h0706050403020100;
      pulse(8'hC0);
      stat_in = '1;
      for (int i = 0; i < NS; i++) read_byte($sformatf("t3_rd%0d", i), 8'(i));
      check("t3_busy", {63'd0, busy}, 64'd0);
      check("t3_oe", {63'd0, vcr_oe}, 64'd0);

      pulse(8'h88); pulse(8'hDE); pulse(8'hAD); pulse(8'hBE); pulse(8'hEF);
      read_byte("t4_rd0", 8'h84);
      read_byte("t4_rd1", 8'hF7);
      read_byte("t4_rd2", 8'hE4);
      read_byte("t4_rd3", 8'hB5);
      check("t4_busy", {63'd0, busy}, 64'd0);

      pulse(8'h10);
      err_m = sat_inc(err_m);
      check("t5_inv_busy", {63'd0, busy}, 64'd0);
      check("t5_inv_err", {56'd0, err_count}, {56'd0, err_m});
      pulse(8'hC0);
      repeat (TO - 20) @(negedge IFCLK);
      check("t5_to_still_busy", {63'd0, busy}, 64'd1);
      cyc = 0;
      while (busy && cyc < 60) begin
         @(negedge IFCLK);
         cyc++;
      end
      check("t5_to_idle", {63'd0, busy}, 64'd0);
      err_m = sat_inc(err_m);
      check("t5_to_err", {56'd0, err_count}, {56'd0, err_m});

      for (int it = 0; it < 150; it++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: begin
               s = int'($urandom_range(0, NC - 1));
               l = int'($urandom_range(1, NC - s));
               pulse(8'(CB + s));
               for (int i = 0; i < l; i++) begin
                  d = 8'($urandom);
                  pulse(d);
                  ctrl_m[s + i] = d;
               end
               check("rnd_wr_busy", {63'd0, busy}, {63'd0, (s + l < NC)});
               check("rnd_wr_ctrl", ctrl_out, ctrl_packed());
            end
            1: begin
               for (int k = 0; k < NS; k++) begin
                  snap_m[k] = 8'($urandom);
                  sv[8*k +: 8] = snap_m[k];
               end
               stat_in = sv;
               s = int'($urandom_range(0, NS - 1));
               l = int'($urandom_range(1, NS - s));
               pulse(8'(SB + s));
               stat_in = {$urandom, $urandom};
               for (int i = 0; i < l; i++) read_byte("rnd_rd", snap_m[s + i]);
               check("rnd_rd_busy", {63'd0, busy}, {63'd0, (s + l < NS)});
            end
            2: begin
               pulse(8'(EA));
               for (int i = 0; i < 4; i++) begin
                  echo_m[i] = 8'($urandom);
                  pulse(echo_m[i]);
               end
               l = int'($urandom_range(1, 4));
               for (int i = 0; i < l; i++) read_byte("rnd_echo", echo_m[i] ^ 8'h5A);
               check("rnd_echo_busy", {63'd0, busy}, {63'd0, (l < 4)});
            end
            default: begin
               a = int'($urandom_range(0, 255));
               while (addr_valid(a)) a = int'($urandom_range(0, 255));
               pulse(8'(a));
               err_m = sat_inc(err_m);
            end
         endcase
         cs_abort();
         check("rnd_err", {56'd0, err_count}, {56'd0, err_m});
      end

      stat_in = 64'h1122334455667788;
      pulse(8'hC0);
      read_byte("t6_rd0", 8'h88);
      read_byte("t6_rd1", 8'h77);
      read_byte("t6_rd2", 8'h66);
      @(negedge IFCLK);
      CS = 1'b0;
      #1;
      check("t6_cs_oe", {63'd0, vcr_oe}, 64'd0);
      @(negedge IFCLK);
      check("t6_cs_busy", {63'd0, busy}, 64'd0);
      check("t6_cs_err", {56'd0, err_count}, {56'd0, err_m});
      check("t6_cs_ctrl", ctrl_out, ctrl_packed());
      CS = 1'b1;
      @(negedge IFCLK);

      for (int i = 0; i < 300; i++) begin
         pulse(8'h10);
         err_m = sat_inc(err_m);
      end
      check("t5_sat", {56'd0, err_count}, 64'hFF);

      pulse(8'hA0); pulse(8'h55);
      ctrl_m[0] = 8'h55;
      check("t6_pre_rst_ctrl", ctrl_out, ctrl_packed());
      @(negedge IFCLK);
      RESET_N = 1'b0;
      @(posedge IFCLK);
      #1;
      check("t6_rst_ctrl", ctrl_out, 64'd0);
      check("t6_rst_err", {56'd0, err_count}, 64'd0);
      check("t6_rst_busy", {63'd0, busy}, 64'd0);
      RESET_N = 1'b1;
      repeat (2) @(negedge IFCLK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
